// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA timing generator: standard VESA
// mode parameter sets and a helper that derives the total period of an axis.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int  VGA640_H_ACTIVE = 640;
  localparam int  VGA640_H_FP     = 16;
  localparam int  VGA640_H_SYNC   = 96;
  localparam int  VGA640_H_BP     = 48;
  localparam int  VGA640_V_ACTIVE = 480;
  localparam int  VGA640_V_FP     = 10;
  localparam int  VGA640_V_SYNC   = 2;
  localparam int  VGA640_V_BP     = 33;
  localparam logic VGA640_HS_POL  = 1'b0;
  localparam logic VGA640_VS_POL  = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam int  SVGA800_H_ACTIVE = 800;
  localparam int  SVGA800_H_FP     = 40;
  localparam int  SVGA800_H_SYNC   = 128;
  localparam int  SVGA800_H_BP     = 88;
  localparam int  SVGA800_V_ACTIVE = 600;
  localparam int  SVGA800_V_FP     = 1;
  localparam int  SVGA800_V_SYNC   = 4;
  localparam int  SVGA800_V_BP     = 23;
  localparam logic SVGA800_HS_POL  = 1'b1;
  localparam logic SVGA800_VS_POL  = 1'b1;

  // 1024x768 @ 60 Hz, 65 MHz pixel clock, both syncs active-low
  localparam int  XGA1024_H_ACTIVE = 1024;
  localparam int  XGA1024_H_FP     = 24;
  localparam int  XGA1024_H_SYNC   = 136;
  localparam int  XGA1024_H_BP     = 160;
  localparam int  XGA1024_V_ACTIVE = 768;
  localparam int  XGA1024_V_FP     = 3;
  localparam int  XGA1024_V_SYNC   = 6;
  localparam int  XGA1024_V_BP     = 29;
  localparam logic XGA1024_HS_POL  = 1'b0;
  localparam logic XGA1024_VS_POL  = 1'b0;

  // Full period of one axis: active + front porch + sync + back porch
  function automatic int total(input int active, input int fp,
                               input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis (horizontal or vertical): a wrapping position counter plus
// combinational decode of the active region and the sync pulse window.
// Segment order along the axis is active, front porch, sync, back porch.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync_act
);

  localparam int TOTAL = total(ACTIVE, FP, SYNC, BP);
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ACT_END    = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(ACTIVE + FP);
  localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FP + SYNC);

  // wrap flags the step that returns the counter to zero; the next axis uses it
  assign wrap     = inc && (cnt == LAST);
  assign active   = (cnt < ACT_END);
  assign sync_act = (cnt >= SYNC_START) && (cnt < SYNC_END);

  // Position counter: steps on ce && inc, wraps from TOTAL-1 to 0
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      cnt <= '0;
    end else if (ce && inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator: hs, vs, data enable, active-area
// coordinates and line/frame start pulses, advancing on a pixel clock-enable.
// All outputs are registered from the decode of the current counters, so they
// lag the counters by one clk and hold while ce is low.
// Optional macro VGA_TIMING_PRE_EN adds de_pre/x_pre/y_pre, which show the
// de/x/y values PRE pixel periods ahead, for sources with read latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   WIDTH    = 11,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PRE      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [WIDTH-1:0] x_coo,
  output logic [WIDTH-1:0] y_coo,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_PRE_EN
  ,
  output logic             de_pre,
  output logic [WIDTH-1:0] x_pre,
  output logic [WIDTH-1:0] y_pre
`endif
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Counters must hold TOTAL-1; the lookahead must stay within one line
  if (H_TOTAL > (2 ** WIDTH) || V_TOTAL > (2 ** WIDTH)) begin : g_width_chk
    $error("vga_timing_gen: WIDTH too small for H_TOTAL/V_TOTAL");
  end
  if (PRE < 1 || PRE > H_ACTIVE) begin : g_pre_chk
    $error("vga_timing_gen: PRE out of range 1..H_ACTIVE");
  end

  logic [WIDTH-1:0] h_cnt, v_cnt;
  logic             h_wrap, h_active, h_sync_act;
  logic             v_active, v_sync_act;
  logic             v_wrap_unused;   // frame start is decoded from h=0,v=0 directly

  vga_axis_cnt #(
    .WIDTH(WIDTH), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst(rst), .ce(ce), .inc(1'b1),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync_act(h_sync_act)
  );

  vga_axis_cnt #(
    .WIDTH(WIDTH), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst(rst), .ce(ce), .inc(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap_unused), .active(v_active), .sync_act(v_sync_act)
  );

  logic at_h0, at_v0;
  assign at_h0 = (h_cnt == '0);
  assign at_v0 = (v_cnt == '0);

  // Output registers: decode loads on ce, start pulses clear on any clk
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      x_coo       <= '0;
      y_coo       <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= ce && at_h0;
      frame_start <= ce && at_h0 && at_v0;
      if (ce) begin
        de    <= h_active && v_active;
        x_coo <= (h_active && v_active) ? h_cnt : '0;
        y_coo <= v_active ? v_cnt : '0;
        hs    <= h_sync_act ? HS_POL : ~HS_POL;
        vs    <= v_sync_act ? VS_POL : ~VS_POL;
      end
    end
  end

`ifdef VGA_TIMING_PRE_EN
  localparam logic [WIDTH:0]   H_TOTAL_X = (WIDTH+1)'(H_TOTAL);
  localparam logic [WIDTH:0]   PRE_X     = (WIDTH+1)'(PRE);
  localparam logic [WIDTH-1:0] V_LAST    = WIDTH'(V_TOTAL - 1);
  localparam logic [WIDTH-1:0] H_ACT_END = WIDTH'(H_ACTIVE);
  localparam logic [WIDTH-1:0] V_ACT_END = WIDTH'(V_ACTIVE);

  logic [WIDTH:0]   h_sum;
  logic [WIDTH-1:0] h_ahead, v_ahead;
  logic             pre_act, pre_v_act;

  // Position PRE pixels ahead; one extra bit keeps h+PRE from overflowing
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    h_ahead = WIDTH'(h_sum);
    v_ahead = v_cnt;
    h_sum   = {1'b0, h_cnt} + PRE_X;
    if (h_sum >= H_TOTAL_X) begin
      h_ahead = WIDTH'(h_sum - H_TOTAL_X);
      v_ahead = (v_cnt == V_LAST) ? '0 : v_cnt + WIDTH'(1);
    end else begin
      h_ahead = WIDTH'(h_sum);
    end
    pre_v_act = (v_ahead < V_ACT_END);
    pre_act   = (h_ahead < H_ACT_END) && pre_v_act;
  end

  // Lookahead registers: same load, hold and reset rules as de/x_coo/y_coo
  always_ff @(posedge clk) begin
    if (rst) begin
      de_pre <= 1'b0;
      x_pre  <= '0;
      y_pre  <= '0;
    end else if (ce) begin
      de_pre <= pre_act;
      x_pre  <= pre_act ? h_ahead : '0;
      y_pre  <= pre_v_act ? v_ahead : '0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 14x8 mode
// (H 8/2/3/1, V 4/1/2/1, both polarities active-low, WIDTH 5).
// Prefetch checks are compiled in when VGA_TIMING_PRE_EN is defined.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic       hs, vs, de, line_start, frame_start;
  logic [4:0] x_coo, y_coo;
`ifdef VGA_TIMING_PRE_EN
  logic       de_pre;
  logic [4:0] x_pre, y_pre;
`endif

  vga_timing_gen #(
    .WIDTH(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PRE(2)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hs(hs), .vs(vs), .de(de), .x_coo(x_coo), .y_coo(y_coo),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_PRE_EN
    , .de_pre(de_pre), .x_pre(x_pre), .y_pre(y_pre)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mh/mv are the position the next ce cycle decodes
  int   mh = 0, mv = 0;
  logic e_de = 0, e_hs = 1, e_vs = 1, e_ls = 0, e_fs = 0;
  int   e_x = 0, e_y = 0;
  logic e_dp = 0;
  int   e_xp = 0, e_yp = 0;
  int   dec_h = 0, dec_v = 0;
  logic dec_ok = 0;
  int   cyc = 0;

  task automatic model_clk(input logic r, input logic c);
    int ph, pv;
    dec_ok = !r && c;
    dec_h  = mh;
    dec_v  = mv;
    if (r) begin
      e_de = 0; e_hs = 1; e_vs = 1; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
      e_dp = 0; e_xp = 0; e_yp = 0;
      mh = 0; mv = 0;
    end else if (c) begin
      e_de = (mh < 8) && (mv < 4);
      e_x  = e_de ? mh : 0;
      e_y  = (mv < 4) ? mv : 0;
      e_hs = !((mh >= 10) && (mh < 13));
      e_vs = !((mv >= 5) && (mv < 7));
      e_ls = (mh == 0);
      e_fs = (mh == 0) && (mv == 0);
      ph = mh + 2;
      pv = mv;
      if (ph >= 14) begin
        ph = ph - 14;
        pv = (mv + 1) % 8;
      end
      e_dp = (ph < 8) && (pv < 4);
      e_xp = e_dp ? ph : 0;
      e_yp = (pv < 4) ? pv : 0;
      mh = mh + 1;
      if (mh == 14) begin
        mh = 0;
        mv = (mv + 1) % 8;
      end
    end else begin
      e_ls = 0;
      e_fs = 0;
    end
  endtask

  // Drive inputs, take one clk edge, sample 1 time unit after it
  task automatic tick(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    model_clk(r, c);
    #1;
    cyc++;
  endtask

`ifdef VGA_TIMING_PRE_EN
  int corner_hits = 0;
`endif

  task automatic check_model();
    check("de", de, e_de);
    check("x_coo", x_coo, e_x);
    check("y_coo", y_coo, e_y);
    check("hs", hs, e_hs);
    check("vs", vs, e_vs);
    check("line_start", line_start, e_ls);
    check("frame_start", frame_start, e_fs);
`ifdef VGA_TIMING_PRE_EN
    check("de_pre", de_pre, e_dp);
    check("x_pre", x_pre, e_xp);
    check("y_pre", y_pre, e_yp);
    if (dec_ok && dec_h == 12 && dec_v == 7) begin
      check("corner_x_pre", x_pre, 0);
      check("corner_y_pre", y_pre, 0);
      check("corner_de_pre", de_pre, 1);
      corner_hits++;
    end
`endif
  endtask

  // Period / run-length monitor, independent of the per-cycle model
  int   mult = 1;
  logic p_de, p_hs, p_vs, p_ls, p_fs, p_dp;
  int   last_ls, last_fs, last_dp_rise;
  int   de_run, hs_run, vs_run;
  logic de_ok, hs_ok, vs_ok;

  task automatic reset_monitor();
    p_de = de; p_hs = hs; p_vs = vs; p_ls = line_start; p_fs = frame_start;
    p_dp = 0;
`ifdef VGA_TIMING_PRE_EN
    p_dp = de_pre;
`endif
    last_ls = -1; last_fs = -1; last_dp_rise = -1;
    de_run = 0; hs_run = 0; vs_run = 0;
    de_ok = 0; hs_ok = 0; vs_ok = 0;
  endtask

  task automatic monitor();
    logic dp;
    dp = 0;
`ifdef VGA_TIMING_PRE_EN
    dp = de_pre;
`endif
    if (line_start) begin
      check("line_start_width", p_ls, 0);
      if (last_ls >= 0) check("line_start_period", cyc - last_ls, 14 * mult);
      last_ls = cyc;
    end
    if (frame_start) begin
      check("frame_start_width", p_fs, 0);
      if (last_fs >= 0) check("frame_start_period", cyc - last_fs, 112 * mult);
      last_fs = cyc;
    end
    if (de) begin
      if (!p_de) begin
        de_run = 0;
        de_ok  = 1;
        if (last_dp_rise >= 0) check("de_pre_lead", cyc - last_dp_rise, 2 * mult);
      end
      de_run++;
    end else if (p_de && de_ok) begin
      check("de_run", de_run, 8 * mult);
    end
    if (dp && !p_dp) last_dp_rise = cyc;
    if (!hs) begin
      if (p_hs) begin hs_run = 0; hs_ok = 1; end
      hs_run++;
    end else if (!p_hs && hs_ok) begin
      check("hs_low_run", hs_run, 3 * mult);
    end
    if (!vs) begin
      if (p_vs) begin vs_run = 0; vs_ok = 1; end
      vs_run++;
    end else if (!p_vs && vs_ok) begin
      check("vs_low_run", vs_run, 28 * mult);
    end
    p_de = de; p_hs = hs; p_vs = vs; p_ls = line_start; p_fs = frame_start;
    p_dp = dp;
  endtask

  typedef struct {
    logic r;
    logic c;
    logic de;
    logic hs;
    logic vs;
    int   x;
    int   y;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[21];

  initial begin
    // Hand-computed start-up sequence: reset, first line, ce gaps
    //            r  c  de hs vs x  y  ls fs
    vecs[0]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 1, 1, 0, 0, 1, 1};  // h0 v0
    vecs[3]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0};  // h1
    vecs[4]  = '{0, 0, 1, 1, 1, 1, 0, 0, 0};  // ce low: hold
    vecs[5]  = '{0, 1, 1, 1, 1, 2, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 1, 1, 3, 0, 0, 0};
    vecs[7]  = '{0, 1, 1, 1, 1, 4, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 1, 1, 5, 0, 0, 0};
    vecs[9]  = '{0, 1, 1, 1, 1, 6, 0, 0, 0};
    vecs[10] = '{0, 1, 1, 1, 1, 7, 0, 0, 0};  // h7, last active pixel
    vecs[11] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};  // h8 front porch
    vecs[12] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};  // h9
    vecs[13] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};  // h10 sync starts
    vecs[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};  // ce low: hold
    vecs[15] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};  // h11
    vecs[16] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};  // h12
    vecs[17] = '{0, 1, 0, 1, 1, 0, 0, 0, 0};  // h13 back porch
    vecs[18] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};  // h0 v1: line start only
    vecs[19] = '{0, 0, 1, 1, 1, 0, 1, 0, 0};  // ce low: pulse falls
    vecs[20] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};  // h1 v1

    for (int i = 0; i < 21; i++) begin
      tick(vecs[i].r, vecs[i].c);
      check($sformatf("v%0d_de", i), de, vecs[i].de);
      check($sformatf("v%0d_hs", i), hs, vecs[i].hs);
      check($sformatf("v%0d_vs", i), vs, vecs[i].vs);
      check($sformatf("v%0d_x", i), x_coo, vecs[i].x);
      check($sformatf("v%0d_y", i), y_coo, vecs[i].y);
      check($sformatf("v%0d_ls", i), line_start, vecs[i].ls);
      check($sformatf("v%0d_fs", i), frame_start, vecs[i].fs);
    end

    // ce held high: more than two full frames
    mult = 1;
    reset_monitor();
    for (int i = 0; i < 240; i++) begin
      tick(0, 1);
      check_model();
      monitor();
    end

    // ce high one clk in three
    mult = 3;
    reset_monitor();
    for (int i = 0; i < 720; i++) begin
      tick(0, (i % 3) == 0);
      check_model();
      monitor();
    end

    // Run to h=5, v=2 and reset for one clk
    mult = 1;
    reset_monitor();
    for (int i = 0; i < 120; i++) begin
      if (mh == 5 && mv == 2) break;
      tick(0, 1);
      check_model();
      monitor();
    end
    check("reached_h5_v2", (mh == 5 && mv == 2), 1);
    tick(1, 1);
    check_model();
    check("rst_de", de, 0);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_x", x_coo, 0);
    check("rst_y", y_coo, 0);
    reset_monitor();
    tick(0, 1);
    check_model();
    check("restart_fs", frame_start, 1);
    check("restart_ls", line_start, 1);
    check("restart_de", de, 1);
    monitor();
    for (int i = 0; i < 230; i++) begin
      tick(0, 1);
      check_model();
      monitor();
    end

    // ce held low: outputs freeze, pulses drop
    for (int i = 0; i < 5; i++) begin
      tick(0, 0);
      check_model();
    end

`ifdef VGA_TIMING_PRE_EN
    check("pre_corner_seen", corner_hits > 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 coordinate/sync generator.
- Produces hs, vs, data-enable, active-area x/y coordinates and line/frame start pulses for any VESA-style mode.
- Supports programmable sync polarity and a pixel clock-enable, so one system clock can serve several pixel rates.
- Sits between the pixel-clock source and the colour/pattern generator.

Parameters:
- WIDTH, 11, width of counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1 (elaboration-time check).
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, asserted level of hs (0 = active-low).
- VS_POL, 0, asserted level of vs.
- PRE, 1, lookahead in pixel periods for the optional prefetch outputs; valid range 1..H_ACTIVE.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- ce  in  1  pixel enable; the pixel counters advance only when ce=1.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- de  out  1  data enable; high inside the active area.
- x_coo  out  WIDTH  horizontal pixel coordinate.
- y_coo  out  WIDTH  vertical line coordinate.
- line_start  out  1  single-clk pulse at h=0.
- frame_start  out  1  single-clk pulse at h=0, v=0.

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise. Line order is active, front porch, sync, back porch.
- Counters h_cnt and v_cnt update only on ce=1:
  - h_cnt increments and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on an h wrap, and wraps from V_TOTAL-1 to 0.
- Every output is a register loaded on a ce=1 cycle from the decode of the current counters. Outputs therefore lag the counters by 1 clk and hold while ce=0.
- de = (h<H_ACTIVE) && (v<V_ACTIVE).
- x_coo = de ? h : 0.
- y_coo = (v<V_ACTIVE) ? v : 0.
- hs is asserted (=HS_POL) when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, otherwise it is ~HS_POL.
- vs uses the same rule on v with V_* parameters and VS_POL.
- line_start and frame_start are 1 on the clk following a ce cycle that decoded h=0 (and v=0 for frame_start). They clear on the next clk whether or not ce is high, so each pulse is exactly 1 clk wide.
- Reset values: h_cnt=0, v_cnt=0, de=0, x_coo=0, y_coo=0, hs=~HS_POL, vs=~VS_POL, line_start=0, frame_start=0.
- After rst falls, the first ce cycle decodes h=0, v=0. On the next clk: de=1, x=0, y=0, frame_start=1, line_start=1.
- rst asserted mid-frame overrides ce and forces the reset values on the next clk; no partial-line completion.
- ce held low indefinitely: all outputs freeze, pulses fall to 0.
- Arithmetic: all comparisons are unsigned WIDTH-bit. No sum may exceed 2^WIDTH-1.

Optional Feature:
- Macro: VGA_TIMING_PRE_EN.
- Defined: adds outputs de_pre (1), x_pre (WIDTH) and y_pre (WIDTH).
  - They equal de/x_coo/y_coo as they will be PRE pixel periods later.
  - They are computed from (h+PRE) with wrap into the next line and frame: past V_TOTAL-1, v wraps to 0.
  - Their timing and reset rules are the same as de/x_coo/y_coo.
  - Purpose: drive ROM or colour sources with PRE cycles of read latency.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - localparam sets for 640x480@60, 800x600@60 and 1024x768@60 (active, porches, sync, polarity);
  - a function computing total = active+fp+sync+bp.
- Sub-module vga_axis_cnt, instantiated once per axis. It takes inc/ce/rst and the four timing parameters, and outputs cnt, wrap, active and sync_act.

Test Plan:
Use the small mode H=8/2/3/1 (H_TOTAL=14), V=4/1/2/1 (V_TOTAL=8), both polarities 0, WIDTH=5.
1. Reset with ce=1 constant:
   - During rst: hs=1, vs=1, de=0.
   - First clk after the first post-release ce: de=1, x=0, y=0, frame_start=1, line_start=1.
2. ce=1 constant:
   - Per active line: de high for exactly 8 clks with x=0..7.
   - hs=0 for exactly 3 clks (h=10..12) every line.
   - line_start period 14 clks.
3. ce=1 constant:
   - vs=0 for exactly 28 clks (v=5,6).
   - frame_start period 112 clks.
   - y_coo=0..3 during de, 0 elsewhere.
4. ce high one clk in three: identical output sequence, frame_start period 336 clks, every pulse exactly 1 clk wide.
5. rst high for one clk at h=5, v=2: next clk shows the reset values; the sequence restarts from h=0, v=0 with a full frame.
6. VGA_TIMING_PRE_EN defined, PRE=2:
   - de_pre rises 2 ce periods before de on every active line.
   - At h=12, v=7: x_pre=0, y_pre=0, de_pre=1.
